// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings and default vectors for the fetch-stage next-PC controller.
package fetch_ctrl_pkg;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_IMM  = 2'd2;

    typedef enum logic [2:0] {
        SRC_SEQ = 3'd0,
        SRC_EXC = 3'd1,
        SRC_INT = 3'd2,
        SRC_POP = 3'd3,
        SRC_JMP = 3'd4
    } pc_src_e;

    localparam logic [31:0] DEF_RESET_VEC    = 32'd32;
    localparam logic [31:0] DEF_INT_VEC      = 32'd0;
    localparam logic [3:0]  DEF_ITYPE_OPCODE = 4'd8;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_req_latch.sv
// Sticky request bit (set beats clear) with an optional payload captured on set.
module fetch_req_latch #(
    parameter int W           = 32,
    parameter bit HAS_PAYLOAD = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         set,
    input  logic         clr,
    input  logic [W-1:0] data_in,
    output logic         pending,
    output logic [W-1:0] data_out
);

    logic pending_r;

    // Pending bit: a repeat request on the service edge keeps it armed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_r <= 1'b0;
        end else begin
            pending_r <= set | (pending_r & ~clr);
        end
    end

    assign pending = pending_r;

    generate
        if (HAS_PAYLOAD) begin : g_payload
            logic [W-1:0] data_r;

            // Payload holding register, refreshed by every new request.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    data_r <= {W{1'b0}};
                end else if (set) begin
                    data_r <= data_in;
                end
            end

            assign data_out = data_r;
        end else begin : g_no_payload
            logic data_unused_s;
            assign data_unused_s = ^data_in;
            assign data_out      = {W{1'b0}};
        end
    endgenerate

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Next-PC controller: latches redirect requests, arbitrates them by fixed
// priority against sequential fetch/stall and sequences two-word I-type fetches.
module fetch_redirect_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VEC    = DEF_RESET_VEC,
    parameter logic [31:0] INT_VEC      = DEF_INT_VEC,
    parameter logic [3:0]  ITYPE_OPCODE = DEF_ITYPE_OPCODE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    input  logic [3:0]  opcode,
    input  logic        stall,
    input  logic        ext_int,
    input  logic        set_int,
    input  logic        exception,
    input  logic        pop_pc,
    input  logic [31:0] pop_value,
    input  logic        jmp_req,
    input  logic [31:0] jmp_target,
    output logic [31:0] pc_next,
    output logic        pc_en,
    output logic        flush,
    output logic        imm_phase,
    output logic        int_ack,
    output logic        exc_ack
);

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic        boot_s;
    logic        hold_s;
    pc_src_e     src_s;

    logic        exc_pend_s, int_pend_s, pop_pend_s, jmp_pend_s;
    logic        exc_clr_s, int_clr_s, pop_clr_s, jmp_clr_s;
    logic        exc_data_unused_s, int_data_unused_s;
    logic [31:0] pop_hold_s, jmp_hold_s;

    fetch_req_latch #(.W(1), .HAS_PAYLOAD(1'b0)) u_exc_req (
        .clk      (clk),
        .reset    (reset),
        .set      (exception),
        .clr      (exc_clr_s),
        .data_in  (1'b0),
        .pending  (exc_pend_s),
        .data_out (exc_data_unused_s)
    );

    fetch_req_latch #(.W(1), .HAS_PAYLOAD(1'b0)) u_int_req (
        .clk      (clk),
        .reset    (reset),
        .set      (ext_int | set_int),
        .clr      (int_clr_s),
        .data_in  (1'b0),
        .pending  (int_pend_s),
        .data_out (int_data_unused_s)
    );

    fetch_req_latch #(.W(32), .HAS_PAYLOAD(1'b1)) u_pop_req (
        .clk      (clk),
        .reset    (reset),
        .set      (pop_pc),
        .clr      (pop_clr_s),
        .data_in  (pop_value),
        .pending  (pop_pend_s),
        .data_out (pop_hold_s)
    );

    fetch_req_latch #(.W(32), .HAS_PAYLOAD(1'b1)) u_jmp_req (
        .clk      (clk),
        .reset    (reset),
        .set      (jmp_req),
        .clr      (jmp_clr_s),
        .data_in  (jmp_target),
        .pending  (jmp_pend_s),
        .data_out (jmp_hold_s)
    );

    // Unused state code 3 is treated like BOOT so the controller self-recovers.
    assign boot_s = (state_r != ST_RUN) && (state_r != ST_IMM);

    // Arbitration: an exception is the only request that overrides a stall.
    always_comb begin
        src_s  = SRC_SEQ;
        hold_s = 1'b0;
        if (boot_s) begin
            src_s  = SRC_SEQ;
            hold_s = 1'b0;
        end else if (exc_pend_s) begin
            src_s = SRC_EXC;
        end else if (stall) begin
            hold_s = 1'b1;
        end else if (int_pend_s) begin
            src_s = SRC_INT;
        end else if (pop_pend_s) begin
            src_s = SRC_POP;
        end else if (jmp_pend_s) begin
            src_s = SRC_JMP;
        end else begin
            src_s = SRC_SEQ;
        end
    end

    assign exc_clr_s = (src_s == SRC_EXC);
    assign int_clr_s = (src_s == SRC_INT);
    assign pop_clr_s = (src_s == SRC_POP);
    assign jmp_clr_s = (src_s == SRC_JMP);

    // Output decode from the registered state and pending requests.
    always_comb begin
        pc_next   = pc_inc(pc_cur);
        pc_en     = 1'b1;
        flush     = 1'b0;
        int_ack   = 1'b0;
        exc_ack   = 1'b0;
        imm_phase = (state_r == ST_IMM);
        if (boot_s) begin
            pc_next = RESET_VEC;
            flush   = 1'b1;
        end else if (hold_s) begin
            pc_en = 1'b0;
        end else begin
            case (src_s)
                SRC_EXC: begin
                    pc_next = RESET_VEC;
                    flush   = 1'b1;
                    exc_ack = 1'b1;
                end
                SRC_INT: begin
                    pc_next = INT_VEC;
                    flush   = 1'b1;
                    int_ack = 1'b1;
                end
                SRC_POP: begin
                    pc_next = pop_hold_s;
                    flush   = 1'b1;
                end
                SRC_JMP: begin
                    pc_next = jmp_hold_s;
                    flush   = 1'b1;
                end
                SRC_SEQ: begin
                    pc_next = pc_inc(pc_cur);
                end
                default: begin
                    pc_next = pc_inc(pc_cur);
                end
            endcase
        end
    end

    // Next state: any redirect aborts an immediate fetch in progress.
    always_comb begin
        state_nxt_s = state_r;
        if (boot_s) begin
            state_nxt_s = ST_RUN;
        end else if (hold_s) begin
            state_nxt_s = state_r;
        end else if (src_s != SRC_SEQ) begin
            state_nxt_s = ST_RUN;
        end else if (state_r == ST_IMM) begin
            state_nxt_s = ST_RUN;
        end else if (opcode == ITYPE_OPCODE) begin
            state_nxt_s = ST_IMM;
        end else begin
            state_nxt_s = ST_RUN;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed scenarios plus randomized traffic checked against a behavioural next-PC model.
module tb_fetch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_cur;
    logic [3:0]  opcode;
    logic        stall, ext_int, set_int, exception, pop_pc, jmp_req;
    logic [31:0] pop_value, jmp_target;
    logic [31:0] pc_next;
    logic        pc_en, flush, imm_phase, int_ack, exc_ack;

    fetch_redirect_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .pc_cur     (pc_cur),
        .opcode     (opcode),
        .stall      (stall),
        .ext_int    (ext_int),
        .set_int    (set_int),
        .exception  (exception),
        .pop_pc     (pop_pc),
        .pop_value  (pop_value),
        .jmp_req    (jmp_req),
        .jmp_target (jmp_target),
        .pc_next    (pc_next),
        .pc_en      (pc_en),
        .flush      (flush),
        .imm_phase  (imm_phase),
        .int_ack    (int_ack),
        .exc_ack    (exc_ack)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model: boot/immediate flags, pending requests indexed by priority
    // (0 exception, 1 interrupt, 2 pop, 3 jump) and the held payloads.
    bit          m_boot;
    bit          m_imm;
    bit          pend [4];
    logic [31:0] h_pop, h_jmp;
    int          m_svc;
    logic [31:0] e_pc;
    logic        e_en, e_fl, e_imm, e_iack, e_eack;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic compute_expected();
        e_pc = pc_cur + 32'd1; e_en = 1'b1; e_fl = 1'b0;
        e_imm = 1'b0; e_iack = 1'b0; e_eack = 1'b0; m_svc = -1;
        if (!reset || m_boot) begin
            e_pc = 32'd32; e_fl = 1'b1;
        end else begin
            e_imm = m_imm;
            for (int i = 3; i >= 0; i--)
                if (pend[i] && (!stall || i == 0)) m_svc = i;
            if (m_svc >= 0) begin
                e_fl = 1'b1;
                case (m_svc)
                    0: begin e_pc = 32'd32; e_eack = 1'b1; end
                    1: begin e_pc = 32'd0;  e_iack = 1'b1; end
                    2: e_pc = h_pop;
                    default: e_pc = h_jmp;
                endcase
            end else if (stall) begin
                e_en = 1'b0;
            end
        end
    endtask

    task automatic model_update();
        if (!reset) begin
            m_boot = 1'b1; m_imm = 1'b0;
            for (int i = 0; i < 4; i++) pend[i] = 1'b0;
            h_pop = 32'd0; h_jmp = 32'd0;
        end else begin
            if (m_boot) begin
                m_boot = 1'b0; m_imm = 1'b0;
            end else if (m_svc >= 0) begin
                pend[m_svc] = 1'b0; m_imm = 1'b0;
            end else if (!stall) begin
                m_imm = m_imm ? 1'b0 : (opcode == 4'd8);
            end
            if (exception) pend[0] = 1'b1;
            if (ext_int || set_int) pend[1] = 1'b1;
            if (pop_pc) begin pend[2] = 1'b1; h_pop = pop_value; end
            if (jmp_req) begin pend[3] = 1'b1; h_jmp = jmp_target; end
        end
    endtask

    // Settle after the inputs were driven, then compare every output to the model.
    task automatic cycle_start();
        #1;
        compute_expected();
        chk("pc_en", {31'd0, pc_en}, {31'd0, e_en});
        chk("flush", {31'd0, flush}, {31'd0, e_fl});
        chk("imm_phase", {31'd0, imm_phase}, {31'd0, e_imm});
        chk("int_ack", {31'd0, int_ack}, {31'd0, e_iack});
        chk("exc_ack", {31'd0, exc_ack}, {31'd0, e_eack});
        if (e_en) chk("pc_next", pc_next, e_pc);
    endtask

    task automatic cycle_end();
        @(posedge clk);
        model_update();
        @(negedge clk);
        if (reset && e_en) pc_cur = e_pc;
        ext_int = 1'b0; set_int = 1'b0; exception = 1'b0;
        pop_pc = 1'b0; jmp_req = 1'b0;
    endtask

    initial begin
        reset = 1'b0; pc_cur = 32'd0; opcode = 4'd0; stall = 1'b0;
        ext_int = 1'b0; set_int = 1'b0; exception = 1'b0;
        pop_pc = 1'b0; pop_value = 32'd0; jmp_req = 1'b0; jmp_target = 32'd0;
        m_boot = 1'b1; m_imm = 1'b0; h_pop = 32'd0; h_jmp = 32'd0;
        for (int i = 0; i < 4; i++) pend[i] = 1'b0;

        // Reset held, then release: BOOT cycle followed by sequential fetch.
        cycle_start();
        chk("rst_pc", pc_next, 32'd32);
        chk("rst_flush", {31'd0, flush}, 32'd1);
        cycle_end();
        reset = 1'b1;
        cycle_start();
        chk("boot_pc", pc_next, 32'd32);
        chk("boot_en", {31'd0, pc_en}, 32'd1);
        cycle_end();
        cycle_start();
        chk("seq_pc", pc_next, 32'd33);
        chk("seq_flush", {31'd0, flush}, 32'd0);
        cycle_end();

        // I-type fetch; opcode 8 during IMM must not re-trigger.
        pc_cur = 32'd40; opcode = 4'd8;
        cycle_start();
        chk("itype_pc", pc_next, 32'd41);
        cycle_end();
        cycle_start();
        chk("imm_flag", {31'd0, imm_phase}, 32'd1);
        chk("imm_pc", pc_next, 32'd42);
        cycle_end();
        opcode = 4'd0;
        cycle_start();
        chk("no_reimm", {31'd0, imm_phase}, 32'd0);
        cycle_end();

        // Jump and interrupt on one edge: interrupt first, jump next.
        jmp_req = 1'b1; jmp_target = 32'h100; ext_int = 1'b1;
        cycle_start();
        cycle_end();
        cycle_start();
        chk("int_pc", pc_next, 32'd0);
        chk("int_ack", {31'd0, int_ack}, 32'd1);
        chk("int_flush", {31'd0, flush}, 32'd1);
        cycle_end();
        cycle_start();
        chk("jmp_pc", pc_next, 32'h100);
        chk("jmp_flush", {31'd0, flush}, 32'd1);
        cycle_end();

        // Stall: pop then exception; exception breaks through, pop waits.
        stall = 1'b1; pop_pc = 1'b1; pop_value = 32'h55;
        cycle_start();
        cycle_end();
        exception = 1'b1;
        cycle_start();
        chk("stall_en", {31'd0, pc_en}, 32'd0);
        cycle_end();
        cycle_start();
        chk("exc_pc", pc_next, 32'd32);
        chk("exc_ack", {31'd0, exc_ack}, 32'd1);
        cycle_end();
        stall = 1'b0;
        cycle_start();
        chk("pop_pc", pc_next, 32'h55);
        cycle_end();

        // Pop arriving during IMM is serviced in the following RUN cycle.
        opcode = 4'd8;
        cycle_start();
        cycle_end();
        opcode = 4'd0; pop_pc = 1'b1; pop_value = 32'h77;
        cycle_start();
        chk("imm_pop_flag", {31'd0, imm_phase}, 32'd1);
        cycle_end();
        cycle_start();
        chk("pop77_pc", pc_next, 32'h77);
        chk("pop77_imm", {31'd0, imm_phase}, 32'd0);
        cycle_end();

        // Wrap-around of the sequential increment.
        pc_cur = 32'hFFFF_FFFF;
        cycle_start();
        chk("wrap_pc", pc_next, 32'd0);
        cycle_end();

        // Reset mid-IMM with a jump pending: the jump must be discarded.
        opcode = 4'd8;
        cycle_start();
        cycle_end();
        opcode = 4'd0; stall = 1'b1; jmp_req = 1'b1; jmp_target = 32'h300;
        cycle_start();
        cycle_end();
        reset = 1'b0;
        cycle_start();
        chk("mid_rst_pc", pc_next, 32'd32);
        chk("mid_rst_imm", {31'd0, imm_phase}, 32'd0);
        cycle_end();
        reset = 1'b1; stall = 1'b0;
        cycle_start();
        cycle_end();
        cycle_start();
        chk("post_rst_pc", pc_next, 32'd33);
        chk("post_rst_flush", {31'd0, flush}, 32'd0);
        cycle_end();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(99) >= 2);
            stall      = ($urandom_range(99) < 25);
            opcode     = ($urandom_range(99) < 20) ? 4'd8 : 4'($urandom_range(15));
            exception  = ($urandom_range(99) < 4);
            ext_int    = ($urandom_range(99) < 6);
            set_int    = ($urandom_range(99) < 4);
            pop_pc     = ($urandom_range(99) < 10);
            jmp_req    = ($urandom_range(99) < 12);
            pop_value  = $urandom;
            jmp_target = $urandom;
            if ($urandom_range(99) < 5) pc_cur = $urandom;
            else if ($urandom_range(99) < 2) pc_cur = 32'hFFFF_FFFF;
            cycle_start();
            cycle_end();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
